// File: rtl/framebuffer_fill_arbiter_pkg.sv
// Shared constants, FSM encoding and the clipping helper for the fill arbiter.
package framebuffer_fill_arbiter_pkg;

   localparam int unsigned FB_WIDTH    = 320;
   localparam int unsigned FB_HEIGHT   = 240;
   localparam logic [31:0] FRAME0_BASE = 32'hFF00_0000;
   localparam logic [31:0] FRAME1_BASE = 32'hFF10_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_e;

   // Clip a span starting at origin to the screen limit; zero when origin is off-screen.
   function automatic logic [9:0] clip_extent(input logic [9:0] origin,
                                              input logic [9:0] extent,
                                              input logic [9:0] limit);
      logic [9:0] room;
      room = limit - origin;
      if (origin >= limit) begin
         clip_extent = 10'd0;
      end else if (extent < room) begin
         clip_extent = extent;
      end else begin
         clip_extent = room;
      end
   endfunction

endpackage

// File: rtl/framebuffer_fill_arbiter_if.sv
// Core bus, framebuffer bus and fill-command signals shared by the arbiter and its user.
interface framebuffer_fill_arbiter_if;

   logic [31:0] core_address;
   logic [31:0] core_write_data;
   logic [3:0]  core_byte_enable;
   logic        core_read_enable;
   logic        core_write_enable;
   logic [31:0] core_data_fetched;

   logic [31:0] fb_address;
   logic [31:0] fb_write_data;
   logic [3:0]  fb_byte_enable;
   logic        fb_read_enable;
   logic        fb_write_enable;
   logic [31:0] fb_data_fetched;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [8:0]  cmd_x0;
   logic [7:0]  cmd_y0;
   logic [8:0]  cmd_width;
   logic [7:0]  cmd_height;
   logic [7:0]  cmd_colour;
   logic        cmd_frame;

   modport slave (
      input  core_address, core_write_data, core_byte_enable, core_read_enable, core_write_enable,
      output core_data_fetched,
      output fb_address, fb_write_data, fb_byte_enable, fb_read_enable, fb_write_enable,
      input  fb_data_fetched,
      input  cmd_valid, cmd_x0, cmd_y0, cmd_width, cmd_height, cmd_colour, cmd_frame,
      output cmd_ready
   );

   modport master (
      output core_address, core_write_data, core_byte_enable, core_read_enable, core_write_enable,
      input  core_data_fetched,
      input  fb_address, fb_write_data, fb_byte_enable, fb_read_enable, fb_write_enable,
      output fb_data_fetched,
      output cmd_valid, cmd_x0, cmd_y0, cmd_width, cmd_height, cmd_colour, cmd_frame,
      input  cmd_ready
   );

endinterface

// File: rtl/framebuffer_fill_arbiter_fill_address_generator.sv
// Walks the clipped fill rectangle one pixel per step, row by row.
module fill_address_generator
   import framebuffer_fill_arbiter_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [8:0]  x0,
   input  logic [7:0]  y0,
   input  logic [8:0]  width,
   input  logic [7:0]  height,
   input  logic        frame,
   output logic        empty,
   output logic [31:0] fill_addr,
   output logic        last
);

   logic [9:0]  w_eff_s;
   logic [9:0]  h_eff_s;
   logic [9:0]  x_end_s;
   logic [9:0]  y_end_s;
   logic [31:0] base_s;

   logic [8:0]  x_r;
   logic [8:0]  x_first_r;
   logic [8:0]  x_last_r;
   logic [7:0]  y_r;
   logic [7:0]  y_last_r;
   logic [31:0] row_base_r;

   assign w_eff_s = clip_extent({1'b0, x0}, {1'b0, width}, 10'(FB_WIDTH));
   assign h_eff_s = clip_extent({2'b00, y0}, {2'b00, height}, 10'(FB_HEIGHT));
   assign empty   = (w_eff_s == 10'd0) || (h_eff_s == 10'd0);
   assign x_end_s = {1'b0, x0} + w_eff_s - 10'd1;
   assign y_end_s = {2'b00, y0} + h_eff_s - 10'd1;
   assign base_s  = frame ? FRAME1_BASE : FRAME0_BASE;

   assign fill_addr = row_base_r + {23'd0, x_r};
   assign last      = (x_r == x_last_r) && (y_r == y_last_r);

   // Latch the clipped rectangle on load, then advance column/row per granted step.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_r        <= 9'd0;
         x_first_r  <= 9'd0;
         x_last_r   <= 9'd0;
         y_r        <= 8'd0;
         y_last_r   <= 8'd0;
         row_base_r <= 32'd0;
      end else if (load) begin
         x_r        <= x0;
         x_first_r  <= x0;
         x_last_r   <= x_end_s[8:0];
         y_r        <= y0;
         y_last_r   <= y_end_s[7:0];
         // Constant-coefficient product for the first row; later rows just add FB_WIDTH.
         row_base_r <= base_s + ({24'd0, y0} * 32'(FB_WIDTH));
      end else if (step) begin
         if (x_r == x_last_r) begin
            x_r        <= x_first_r;
            y_r        <= y_r + 8'd1;
            row_base_r <= row_base_r + 32'(FB_WIDTH);
         end else begin
            x_r <= x_r + 9'd1;
         end
      end else begin
         x_r <= x_r;
      end
   end

endmodule

// File: rtl/framebuffer_fill_arbiter.sv
// Shares the framebuffer port between core accesses and idle-cycle rectangle fills,
// and schedules double-buffer swaps onto vertical-blank rising edges.
module framebuffer_fill_arbiter
   import framebuffer_fill_arbiter_pkg::*;
(
   input  logic                            clock,
   input  logic                            reset,
   framebuffer_fill_arbiter_if.slave       bus,
   output logic                            fill_busy,
   output logic                            fill_done,
   input  logic                            swap_request,
   input  logic                            vblank,
   output logic                            frame_select,
   output logic                            swap_done
);

   fill_state_e state_r;
   fill_state_e state_next_s;
   logic [7:0]  colour_r;
   logic        load_s;
   logic        step_s;
   logic        empty_s;
   logic        last_s;
   logic [31:0] fill_addr_s;
   logic        core_active_s;
   logic        vblank_q_r;
   logic        swap_pending_r;
   logic        frame_select_r;
   logic        swap_done_r;
   logic        swap_go_s;

   assign core_active_s = bus.core_read_enable | bus.core_write_enable;
   assign step_s        = (state_r == ST_FILL) && !core_active_s;
   assign bus.cmd_ready = (state_r == ST_IDLE) && !reset;
   assign fill_busy     = (state_r == ST_FILL);
   assign fill_done     = (state_r == ST_DONE);
   assign bus.core_data_fetched = bus.fb_data_fetched;

   fill_address_generator u_addr_gen (
      .clock     (clock),
      .reset     (reset),
      .load      (load_s),
      .step      (step_s),
      .x0        (bus.cmd_x0),
      .y0        (bus.cmd_y0),
      .width     (bus.cmd_width),
      .height    (bus.cmd_height),
      .frame     (bus.cmd_frame),
      .empty     (empty_s),
      .fill_addr (fill_addr_s),
      .last      (last_s)
   );

   // Fill state register and the colour captured at command acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         colour_r <= 8'd0;
      end else begin
         state_r <= state_next_s;
         if (load_s) begin
            colour_r <= bus.cmd_colour;
         end else begin
            colour_r <= colour_r;
         end
      end
   end

   // Next-state logic: accept in IDLE, step through pixels in FILL, pulse DONE once.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               load_s       = 1'b1;
               state_next_s = empty_s ? ST_DONE : ST_FILL;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (step_s && last_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_FILL;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bus mux: core has absolute priority, fill writes take the idle cycles.
   always_comb begin
      bus.fb_address      = 32'd0;
      bus.fb_write_data   = 32'd0;
      bus.fb_byte_enable  = 4'd0;
      bus.fb_read_enable  = 1'b0;
      bus.fb_write_enable = 1'b0;
      if (core_active_s) begin
         bus.fb_address      = bus.core_address;
         bus.fb_write_data   = bus.core_write_data;
         bus.fb_byte_enable  = bus.core_byte_enable;
         bus.fb_read_enable  = bus.core_read_enable;
         bus.fb_write_enable = bus.core_write_enable;
      end else if (state_r == ST_FILL) begin
         bus.fb_address      = fill_addr_s;
         bus.fb_write_data   = {4{colour_r}};
         bus.fb_byte_enable  = 4'b0001 << fill_addr_s[1:0];
         bus.fb_write_enable = 1'b1;
      end else begin
         bus.fb_address = 32'd0;
      end
   end

   // A swap fires only on a vblank rising edge while pending and no fill is in flight.
   assign swap_go_s    = vblank && !vblank_q_r && swap_pending_r && (state_r == ST_IDLE);
   assign frame_select = frame_select_r;
   assign swap_done    = swap_done_r;

   // Swap bookkeeping; a request coinciding with the swap it triggers is absorbed.
   always_ff @(posedge clock) begin
      if (reset) begin
         vblank_q_r     <= 1'b0;
         swap_pending_r <= 1'b0;
         frame_select_r <= 1'b0;
         swap_done_r    <= 1'b0;
      end else begin
         vblank_q_r  <= vblank;
         swap_done_r <= swap_go_s;
         if (swap_go_s) begin
            frame_select_r <= ~frame_select_r;
            swap_pending_r <= 1'b0;
         end else if (swap_request) begin
            swap_pending_r <= 1'b1;
         end else begin
            swap_pending_r <= swap_pending_r;
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_fill_arbiter.sv
// Scoreboard bench for framebuffer_fill_arbiter: a rectangle model queues expected pixel
// writes; a negedge monitor pops and compares whatever the bus presents.
module tb_framebuffer_fill_arbiter;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } wr_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic fill_busy, fill_done, frame_select, swap_done;
   logic swap_request = 1'b0;
   logic vblank = 1'b0;

   framebuffer_fill_arbiter_if bus ();

   framebuffer_fill_arbiter dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .fill_busy    (fill_busy),
      .fill_done    (fill_done),
      .swap_request (swap_request),
      .vblank       (vblank),
      .frame_select (frame_select),
      .swap_done    (swap_done)
   );

   always #5 clock = ~clock;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   int  hs_cyc = 0;
   int  exp_prev = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  swap_cnt = 0;
   int  core_mode = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Reference: clip the rectangle with plain arithmetic and list every pixel in raster order.
   task automatic issue(input int x0, input int y0, input int w, input int h,
                        input logic [7:0] col, input logic fr);
      int guard;
      int we;
      int he;
      logic [31:0] base;
      wr_t e;
      guard = 0;
      while (!bus.cmd_ready && guard < 300) begin
         tick(1);
         guard++;
      end
      if (!bus.cmd_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL cmd_ready_wait: got 0, expected 1 within budget");
      end
      we = (x0 >= 320) ? 0 : ((w < 320 - x0) ? w : 320 - x0);
      he = (y0 >= 240) ? 0 : ((h < 240 - y0) ? h : 240 - y0);
      base = fr ? 32'hFF10_0000 : 32'hFF00_0000;
      hs_cyc   = cyc;
      exp_prev = cyc;
      for (int yy = 0; yy < he; yy++) begin
         for (int xx = 0; xx < we; xx++) begin
            e.a  = base + 32'((y0 + yy) * 320 + x0 + xx);
            e.be = 4'b0001 << e.a[1:0];
            e.d  = {4{col}};
            exp_q.push_back(e);
         end
      end
      bus.cmd_x0     = 9'(x0);
      bus.cmd_y0     = 8'(y0);
      bus.cmd_width  = 9'(w);
      bus.cmd_height = 8'(h);
      bus.cmd_colour = col;
      bus.cmd_frame  = fr;
      bus.cmd_valid  = 1'b1;
      tick(1);
      bus.cmd_valid  = 1'b0;
      bus.cmd_x0     = 9'($urandom);
      bus.cmd_width  = 9'($urandom);
      bus.cmd_colour = 8'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int start;
      int k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < budget) begin
         tick(1);
         k++;
      end
      if (done_cnt == start) begin
         n_cmp++;
         n_bad++;
         $display("FAIL fill_done_wait: no fill_done within %0d cycles", budget);
      end
      tick(1);
   endtask

   // Cycle counter: cycle k is the interval after the k-th rising edge.
   initial forever begin
      @(posedge clock);
      cyc = cyc + 1;
   end

   // Core-side traffic generator: off, strictly alternating, or random reads.
   initial forever begin
      @(posedge clock);
      #2;
      bus.core_address     = $urandom;
      bus.core_byte_enable = 4'($urandom);
      bus.fb_data_fetched  = $urandom;
      case (core_mode)
         1:       bus.core_read_enable = (((cyc - hs_cyc) % 2) == 1);
         2:       bus.core_read_enable = ($urandom_range(0, 2) == 0);
         default: bus.core_read_enable = 1'b0;
      endcase
   end

   // Monitor: compares whatever the bus shows against the scoreboard, away from the clock edge.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.core_read_enable) begin
            check("core_passthrough",
                  {bus.fb_address, bus.fb_byte_enable, bus.fb_read_enable, bus.fb_write_enable},
                  {bus.core_address, bus.core_byte_enable, 1'b1, 1'b0});
            check("core_data_fetched", bus.core_data_fetched, bus.fb_data_fetched);
         end else if (bus.fb_write_enable) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_write: got write to %h, expected none", bus.fb_address);
            end else begin
               mon_e = exp_q.pop_front();
               check("fill_write",
                     {bus.fb_read_enable, bus.fb_address, bus.fb_byte_enable, bus.fb_write_data},
                     {1'b0, mon_e.a, mon_e.be, mon_e.d});
               exp_prev = cyc;
            end
         end else begin
            check("idle_bus_zero",
                  {bus.fb_address, bus.fb_write_data, bus.fb_byte_enable, bus.fb_read_enable},
                  {32'd0, 32'd0, 4'd0, 1'b0});
         end
         if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_queue_empty", 96'(exp_q.size()), 96'd0);
            check("done_timing", 96'(cyc), 96'(exp_prev + 1));
         end
         if (swap_done) swap_cnt++;
      end
   end

   initial begin
      int n0;
      int s0;
      int d0;
      bus.core_address      = 32'd0;
      bus.core_write_data   = 32'd0;
      bus.core_byte_enable  = 4'd0;
      bus.core_read_enable  = 1'b0;
      bus.core_write_enable = 1'b0;
      bus.fb_data_fetched   = 32'd0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_x0     = 9'd0;
      bus.cmd_y0     = 8'd0;
      bus.cmd_width  = 9'd0;
      bus.cmd_height = 8'd0;
      bus.cmd_colour = 8'd0;
      bus.cmd_frame  = 1'b0;

      // Reset behaviour
      tick(3);
      check("ready_in_reset", bus.cmd_ready, 1'b0);
      reset = 1'b0;
      tick(1);
      check("reset_state",
            {bus.cmd_ready, fill_busy, fill_done, frame_select, swap_done, bus.fb_write_enable},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

      // Test 1: 4x2 fill on an idle bus
      issue(0, 0, 4, 2, 8'hAB, 1'b0);
      n0 = hs_cyc;
      wait_done(100);
      check("t1_done_cycle", 96'(done_cyc - n0), 96'd9);

      // Test 2: same fill with core reads on alternate cycles
      core_mode = 1;
      issue(0, 0, 4, 2, 8'hAB, 1'b0);
      n0 = hs_cyc;
      wait_done(100);
      check("t2_done_cycle", 96'(done_cyc - n0), 96'd17);
      core_mode = 0;
      tick(1);

      // Test 3: clipping at right edge, off-screen origins, bottom edge
      issue(318, 0, 10, 1, 8'h5A, 1'b0);
      n0 = hs_cyc;
      wait_done(100);
      check("t3_clip_done_cycle", 96'(done_cyc - n0), 96'd3);
      issue(320, 5, 10, 3, 8'h11, 1'b0);
      n0 = hs_cyc;
      wait_done(100);
      check("t3_empty_x_done_cycle", 96'(done_cyc - n0), 96'd1);
      issue(7, 240, 4, 4, 8'h22, 1'b1);
      n0 = hs_cyc;
      wait_done(100);
      check("t3_empty_y_done_cycle", 96'(done_cyc - n0), 96'd1);
      issue(2, 238, 3, 9, 8'hC3, 1'b1);
      n0 = hs_cyc;
      wait_done(100);
      check("t3_bottom_done_cycle", 96'(done_cyc - n0), 96'd7);

      // Test 4: swap requested mid-fill waits for a vblank rise in IDLE
      s0 = swap_cnt;
      issue(0, 10, 100, 2, 8'h3C, 1'b1);
      tick(3);
      swap_request = 1'b1;
      tick(1);
      swap_request = 1'b0;
      tick(2);
      vblank = 1'b1;
      tick(4);
      check("t4_no_toggle_midfill", {frame_select, 8'(swap_cnt - s0)}, {1'b0, 8'd0});
      vblank = 1'b0;
      wait_done(400);
      tick(2);
      vblank = 1'b1;
      tick(3);
      check("t4_toggle_after_idle", {frame_select, 8'(swap_cnt - s0)}, {1'b1, 8'd1});
      vblank = 1'b0;
      tick(2);

      // Repeated requests collapse into one swap
      for (int i = 0; i < 3; i++) begin
         swap_request = 1'b1;
         tick(1);
         swap_request = 1'b0;
         tick(1);
      end
      vblank = 1'b1;
      tick(3);
      check("t4_collapse", {frame_select, 8'(swap_cnt - s0)}, {1'b0, 8'd2});
      vblank = 1'b0;
      tick(2);

      // Request coinciding with the qualifying rise is absorbed
      swap_request = 1'b1;
      tick(1);
      vblank = 1'b1;
      tick(1);
      swap_request = 1'b0;
      tick(2);
      check("t4_absorb_toggle", {frame_select, 8'(swap_cnt - s0)}, {1'b1, 8'd3});
      vblank = 1'b0;
      tick(2);
      vblank = 1'b1;
      tick(3);
      check("t4_absorb_no_second", {frame_select, 8'(swap_cnt - s0)}, {1'b1, 8'd3});
      vblank = 1'b0;
      tick(2);

      // Test 5: reset during the third pixel write aborts the fill
      d0 = done_cnt;
      issue(0, 0, 4, 2, 8'hAB, 1'b0);
      tick(2);
      reset = 1'b1;
      #1;
      check("t5_ready_in_reset", bus.cmd_ready, 1'b0);
      tick(1);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("t5_after_reset",
            {fill_busy, bus.fb_write_enable, frame_select, fill_done, swap_done},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tick(12);
      check("t5_no_done_pulse", 96'(done_cnt - d0), 96'd0);
      issue(5, 5, 3, 3, 8'h77, 1'b1);
      n0 = hs_cyc;
      wait_done(100);
      check("t5_new_cmd_done_cycle", 96'(done_cyc - n0), 96'd10);

      // Randomized fills under random core contention
      core_mode = 2;
      for (int i = 0; i < 25; i++) begin
         issue($urandom_range(0, 330), $urandom_range(0, 245), $urandom_range(0, 24),
               $urandom_range(0, 5), 8'($urandom), 1'($urandom));
         wait_done(3000);
      end
      core_mode = 0;
      tick(2);
      check("final_queue_empty", 96'(exp_q.size()), 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time bound so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

endmodule
